// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Purpose  : Encodes decoded ADDI/JAL fields into RV32I machine words and
//             hands them to an instruction-memory writer with running addresses.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_ty,
  input  logic [4:0]        in_rd,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rs1,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [15:0]       word_count
);

  localparam logic [ADDR_W-1:0] c_BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_STEP      = ADDR_W'(4);
  localparam logic [31:0]       c_TY_ADDI   = 32'd0;
  localparam logic [31:0]       c_TY_JAL    = 32'd1;
  localparam logic [6:0]        c_OP_ADDI   = 7'b0010011;
  localparam logic [6:0]        c_OP_JAL    = 7'b1101111;
  localparam logic [1:0]        c_ERR_NONE  = 2'd0;
  localparam logic [1:0]        c_ERR_TYPE  = 2'd1;
  localparam logic [1:0]        c_ERR_RANGE = 2'd2;
  localparam logic [1:0]        c_ERR_ALIGN = 2'd3;

  logic              r_out_valid;
  logic [31:0]       r_out_word;
  logic [ADDR_W-1:0] r_out_addr;
  logic [15:0]       r_word_count;
  logic              r_err_valid;
  logic [1:0]        r_err_code;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_addi_fits;
  logic              w_jal_fits;
  logic [31:0]       w_word;
  logic [1:0]        w_err;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  // Immediate fits when every bit above the encodable field is a sign copy.
  assign w_addi_fits = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign w_jal_fits  = (&in_imm[31:20]) || !(|in_imm[31:20]);

  always_comb begin
    w_word = '0;
    w_err  = c_ERR_NONE;
    if (in_ty == c_TY_ADDI) begin
      w_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, c_OP_ADDI};
      if (in_funct3 != 3'd0) begin
        w_err = c_ERR_TYPE;
      end else if (!w_addi_fits) begin
        w_err = c_ERR_RANGE;
      end
    end else if (in_ty == c_TY_JAL) begin
      w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, c_OP_JAL};
      if (in_imm[0]) begin
        w_err = c_ERR_ALIGN;
      end else if (!w_jal_fits) begin
        w_err = c_ERR_RANGE;
      end
    end else begin
      w_err = c_ERR_TYPE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_word   <= '0;
      r_out_addr   <= c_BASE;
      r_word_count <= '0;
      r_err_valid  <= 1'b0;
      r_err_code   <= c_ERR_NONE;
    end else begin
      // The address register always names the slot of the word being held,
      // so it advances only when a word actually leaves.
      if (w_out_fire) begin
        r_out_addr   <= r_out_addr + c_STEP;
        r_word_count <= r_word_count + 16'd1;
      end
      if (w_in_fire && (w_err == c_ERR_NONE)) begin
        r_out_valid <= 1'b1;
        r_out_word  <= w_word;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
      r_err_valid <= w_in_fire && (w_err != c_ERR_NONE);
      r_err_code  <= w_in_fire ? w_err : c_ERR_NONE;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_word   = r_out_word;
  assign out_addr   = r_out_addr;
  assign word_count = r_word_count;
  assign err_valid  = r_err_valid;
  assign err_code   = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder
//  Purpose  : Scoreboard bench for instr_encoder (encoding, errors, stall, reset).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  localparam logic [31:0] c_BASE = 32'h0000_1000;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ty;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] word_count;

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] a;
  } exp_t;

  exp_t        sb[$];
  logic [1:0]  eq[$];
  logic [31:0] exp_addr;
  int          n_vec;
  int          n_err;

  instr_encoder #(.BASE_ADDR(c_BASE), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ty(in_ty), .in_rd(in_rd),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .err_valid(err_valid), .err_code(err_code),
    .word_count(word_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Offer one input; returns at the falling edge after it was accepted.
  task automatic send(input logic [31:0] ty, input logic [4:0] rd, input logic [2:0] f3,
                      input logic [4:0] rs1, input logic [31:0] imm,
                      input logic [31:0] exp_word, input logic [1:0] exp_err);
    int n;
    in_valid = 1'b1; in_ty = ty; in_rd = rd; in_funct3 = f3; in_rs1 = rs1; in_imm = imm;
    n = 0;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end else if (exp_err == 2'd0) begin
      sb.push_back('{w: exp_word, a: exp_addr});
      exp_addr = exp_addr + 32'd4;
    end else begin
      eq.push_back(exp_err);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || eq.size() != 0) && n < 100) begin
      @(negedge clk); #3;
      n++;
    end
    n_vec++;
    if (sb.size() != 0 || eq.size() != 0) begin
      n_err++;
      $display("FAIL drain: words left %0d errs left %0d required 0/0", sb.size(), eq.size());
    end
    @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    logic [1:0] c;
    forever begin
      @(negedge clk); #2;
      if (!rst && out_valid && out_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_word: got %h @%h required none", out_word, out_addr);
        end else begin
          e = sb.pop_front();
          if (out_word !== e.w || out_addr !== e.a) begin
            n_err++;
            $display("FAIL word: got %h @%h required %h @%h", out_word, out_addr, e.w, e.a);
          end
        end
      end
      if (!rst && err_valid) begin
        n_vec++;
        if (eq.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_err: got code %0d required no pulse", err_code);
        end else begin
          c = eq.pop_front();
          if (err_code !== c) begin
            n_err++;
            $display("FAIL err_code: got %0d required %0d", err_code, c);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_ty = '0; in_rd = '0; in_funct3 = '0; in_rs1 = '0; in_imm = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || out_word !== 32'h0 || out_addr !== c_BASE ||
        word_count !== 16'h0 || err_valid !== 1'b0 || err_code !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b w=%h a=%h cnt=%h e=%b/%0d required 0/0/%h/0/0/0",
               out_valid, out_word, out_addr, word_count, err_valid, err_code, c_BASE);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_addi();
    send(32'd0, 5'd1, 3'd0, 5'd0, 32'd5, 32'h0050_0093, 2'd0);
    n_vec++;
    if (out_valid !== 1'b1 || out_word !== 32'h0050_0093) begin
      n_err++;
      $display("FAIL addi_latency: got v=%b w=%h required 1 00500093", out_valid, out_word);
    end
    send(32'd0, 5'd2, 3'd0, 5'd1, 32'hFFFF_FFFF, 32'hFFF0_8113, 2'd0);
    n_vec++;
    if (out_valid !== 1'b1 || out_word !== 32'hFFF0_8113 || out_addr !== c_BASE + 32'd4) begin
      n_err++;
      $display("FAIL back_to_back: got v=%b w=%h a=%h required 1 fff08113 %h",
               out_valid, out_word, out_addr, c_BASE + 32'd4);
    end
    send(32'd0, 5'd1, 3'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0093, 2'd0);
    drain();
    n_vec++;
    if (word_count !== 16'd3) begin
      n_err++;
      $display("FAIL addi_count: got %0d required 3", word_count);
    end
  endtask

  task automatic test_jal();
    send(32'd1, 5'd1, 3'd5, 5'd9, 32'd8, 32'h0080_00EF, 2'd0);
    send(32'd1, 5'd0, 3'd0, 5'd0, 32'hFFFF_FFFC, 32'hFFDF_F06F, 2'd0);
    drain();
    n_vec++;
    if (word_count !== 16'd5 || out_addr !== c_BASE + 32'h14) begin
      n_err++;
      $display("FAIL jal_count: got cnt=%0d a=%h required 5 %h", word_count, out_addr, c_BASE + 32'h14);
    end
  endtask

  task automatic test_errors();
    send(32'd0, 5'd1, 3'd0, 5'd0, 32'd2048,      32'h0, 2'd2);
    send(32'd1, 5'd1, 3'd0, 5'd0, 32'd3,         32'h0, 2'd3);
    send(32'd5, 5'd1, 3'd0, 5'd0, 32'd0,         32'h0, 2'd1);
    send(32'd0, 5'd1, 3'd1, 5'd0, 32'd1,         32'h0, 2'd1);
    send(32'd1, 5'd1, 3'd0, 5'd0, 32'h0010_0000, 32'h0, 2'd2);
    send(32'd1, 5'd1, 3'd0, 5'd0, 32'h0010_0001, 32'h0, 2'd3);
    drain();
    n_vec++;
    if (out_valid !== 1'b0 || word_count !== 16'd5 || out_addr !== c_BASE + 32'h14) begin
      n_err++;
      $display("FAIL err_no_side_effect: got v=%b cnt=%0d a=%h required 0 5 %h",
               out_valid, word_count, out_addr, c_BASE + 32'h14);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    send(32'd0, 5'd3, 3'd0, 5'd2, 32'h0000_07FF, 32'h7FF1_0193, 2'd0);
    fork
      send(32'd1, 5'd5, 3'd0, 5'd0, 32'h0000_0FFE, 32'h7FF0_02EF, 2'd0);
      begin
        repeat (3) begin
          @(negedge clk); #2;
          n_vec++;
          if (out_valid !== 1'b1 || out_word !== 32'h7FF1_0193 ||
              out_addr !== c_BASE + 32'h14 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold: got v=%b w=%h a=%h rdy=%b required 1 7ff10193 %h 0",
                     out_valid, out_word, out_addr, in_ready, c_BASE + 32'h14);
          end
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    n_vec++;
    if (out_valid !== 1'b0 || word_count !== 16'd7 || out_addr !== c_BASE + 32'h1C) begin
      n_err++;
      $display("FAIL stall_release: got v=%b cnt=%0d a=%h required 0 7 %h",
               out_valid, word_count, out_addr, c_BASE + 32'h1C);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(32'd0, 5'd4, 3'd0, 5'd4, 32'd1, 32'h0012_0213, 2'd0);
    rst = 1'b1;
    @(negedge clk); #2;
    n_vec++;
    if (out_valid !== 1'b0 || out_word !== 32'h0 || out_addr !== c_BASE ||
        word_count !== 16'd0 || err_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got v=%b w=%h a=%h cnt=%0d e=%b required 0 0 %h 0 0",
               out_valid, out_word, out_addr, word_count, err_valid, c_BASE);
    end
    sb.delete();
    exp_addr = c_BASE;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_ready: got %b required 1", in_ready);
    end
    out_ready = 1'b1;
    send(32'd0, 5'd7, 3'd0, 5'd0, 32'd0, 32'h0000_0393, 2'd0);
    drain();
    n_vec++;
    if (word_count !== 16'd1 || out_addr !== c_BASE + 32'd4) begin
      n_err++;
      $display("FAIL post_reset_count: got cnt=%0d a=%h required 1 %h", word_count, out_addr, c_BASE + 32'd4);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_addr = c_BASE;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_ty = '0; in_rd = '0; in_funct3 = '0; in_rs1 = '0; in_imm = '0;
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
      end
    join_none
    test_reset();
    test_addi();
    test_jal();
    test_errors();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address assigned to the first emitted word.
REQ-002 Parameter ADDR_W, default 32, width of out_addr.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port in_valid  input  1  decoded instruction present.
REQ-006 Port in_ready  output  1  encoder accepts this cycle.
REQ-007 Port in_ty  input  32  instruction type: 0 = ADDI, 1 = JAL, all other values unsupported.
REQ-008 Ports in_rd  input  5, in_funct3  input  3, in_rs1  input  5, in_imm  input  32  decoded fields; in_imm is sign-extended.
REQ-009 Port out_valid  output  1  encoded word held.
REQ-010 Port out_ready  input  1  downstream (instruction-memory writer) accepts.
REQ-011 Port out_word  output  32  RV32I machine word.
REQ-012 Port out_addr  output  ADDR_W  byte address of out_word.
REQ-013 Port err_valid  output  1  one-cycle pulse: the accepted input was rejected.
REQ-014 Port err_code  output  2  0 = none, 1 = unsupported type or bad funct3, 2 = immediate out of range, 3 = JAL immediate misaligned.
REQ-015 Port word_count  output  16  number of words handed off downstream.

Function
REQ-016 Input transfer on in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-017 in_ready = !out_valid || out_ready (combinational), giving full throughput with a single output register.
REQ-018 Latency: a valid input accepted at edge N presents out_valid with its word from edge N onward (visible cycle N+1).
REQ-019 ADDI encoding: {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011}.
REQ-020 ADDI is legal only when in_funct3 == 0 (else err_code 1) and in_imm[31:11] are all equal (else err_code 2).
REQ-021 JAL encoding: {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111}; in_rs1 and in_funct3 are ignored.
REQ-022 JAL is legal only when in_imm[0] == 0 (else err_code 3) and in_imm[31:20] are all equal (else err_code 2); misalignment is checked before range.
REQ-023 in_ty values other than 0 or 1 give err_code 1.
REQ-024 A rejected input is consumed (in_ready behaves as for a legal input), emits no word, and does not advance out_addr or word_count.
REQ-025 err_valid/err_code are registered: asserted during the cycle after the rejecting transfer, then return to 0/0.
REQ-026 out_addr starts at BASE_ADDR and increments by 4 (wrapping modulo 2^ADDR_W) on each output transfer; it is always the address of the word currently held.
REQ-027 word_count increments on each output transfer and wraps 16'hFFFF -> 0.
REQ-028 When the held word is taken and a new legal input is accepted in the same cycle, the register reloads with no bubble, and out_valid stays 1.
REQ-029 While out_valid && !out_ready: out_word and out_addr stay stable and in_ready = 0.
REQ-030 in_rd = 0 is encoded as-is; no special casing.

Reset
REQ-031 While rst = 1 at an edge: out_valid = 0, out_word = 0, out_addr = BASE_ADDR, word_count = 0, err_valid = 0, err_code = 0.
REQ-032 Reset mid-operation discards any held word without a handoff; in_ready = 1 in the cycle after reset releases.

Verification
REQ-033 ADDI rd=1 rs1=0 imm=5, then ADDI rd=2 rs1=1 imm=32'hFFFFFFFF with out_ready=1 -> words 32'h00500093 @0x0, then 32'hFFF08113 @0x4, back-to-back, word_count=2.
REQ-034 JAL rd=1 imm=8, then JAL rd=0 imm=32'hFFFFFFFC -> 32'h008000EF, then 32'hFFDFF06F.
REQ-035 ADDI imm=2048, JAL imm=3, in_ty=5 -> err_code 2, 3, 1 pulsed once each; no out_valid; out_addr and word_count unchanged.
REQ-036 out_ready=0 with 2 inputs offered -> first word held stable, in_ready=0; raise out_ready -> both words delivered in order with consecutive addresses.
REQ-037 Assert rst while a word is held and out_ready=0 -> out_valid=0, out_addr=BASE_ADDR, word_count=0 next cycle; the next ADDI is emitted at BASE_ADDR.
